// File: rtl/nco_quadlut_if.sv
// Sample/control bundle between the loop filter and the NCO, plus sin/cos result bus.
// Pure wiring, no latency; no backpressure, results are valid-qualified only.
// master drives error/control, slave (the NCO) drives phase and sin/cos terms.
interface nco_quadlut_if #(
    parameter int PHASE_W = 32,
    parameter int ERR_W   = 32,
    parameter int OUT_W   = 16
);
    logic               in_valid;
    logic [ERR_W-1:0]   error;
    logic               fcw_load;
    logic [PHASE_W-1:0] fcw_in;
    logic [PHASE_W-1:0] phase_offset;
    logic               sync_clr;
    logic [PHASE_W-1:0] phase_out;
    logic [OUT_W-1:0]   sinterm;
    logic [OUT_W-1:0]   costerm;
    logic               out_valid;

    modport master (
        output in_valid, error, fcw_load, fcw_in, phase_offset, sync_clr,
        input  phase_out, sinterm, costerm, out_valid
    );

    modport slave (
        input  in_valid, error, fcw_load, fcw_in, phase_offset, sync_clr,
        output phase_out, sinterm, costerm, out_valid
    );
endinterface

// File: rtl/nco_quadlut.sv
// Costas-loop NCO: phase accumulator (fcw + scaled signed error) into quarter-wave sin/cos ROM.
// Latency 3 clk from accepted in_valid to out_valid; phase_out updates on the accepting edge.
// No backpressure: one sample per clk always accepted; sync_clr squashes everything in flight.
module nco_quadlut #(
    parameter int                 PHASE_W   = 32,
    parameter int                 ERR_W     = 32,
    parameter int                 ERR_SHIFT = 3,
    parameter int                 ANGLE_W   = 10,
    parameter int                 OUT_W     = 16,
    parameter logic [PHASE_W-1:0] FCW_INIT  = '0,
    parameter string              LUT_FILE  = "qsin.hex"
) (
    input  logic         clk,
    input  logic         reset,
    nco_quadlut_if.slave bus
);
    localparam int  R_W   = ANGLE_W - 2;
    localparam int  N     = 1 << R_W;
    localparam int  LUT_W = OUT_W - 1;
    localparam real PI    = 3.14159265358979323846;

    if (ANGLE_W < 3 || ERR_W > PHASE_W || LUT_FILE == "") begin : g_bad_params
        $error("nco_quadlut: unsupported parameter set");
    end

    // Table entry k = round(A*sin((2k+1)*pi/(4N))); half-step offset keeps folding symmetric.
    function automatic logic [LUT_W-1:0] lut_entry(input int k);
        real x, term, acc;
        x    = real'(2 * k + 1) * PI / real'(4 * N);
        term = x;
        acc  = x;
        for (int i = 1; i < 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        return LUT_W'($rtoi(acc * real'((1 << (OUT_W - 1)) - 1) + 0.5));
    endfunction

    logic [LUT_W-1:0] rom [N];
    for (genvar k = 0; k < N; k++) begin : g_rom
        assign rom[k] = lut_entry(k);
    end

    logic [PHASE_W-1:0] phase_acc_q, phase_acc_d, fcw_q, fcw_d;
    logic [ANGLE_W-1:0] ang_a_q, ang_a_d;
    logic               va_q, va_d, vb_q, vb_d, out_valid_q, out_valid_d;
    logic [LUT_W-1:0]   sin_mag_q, sin_mag_d, cos_mag_q, cos_mag_d;
    logic               sin_neg_q, sin_neg_d, cos_neg_q, cos_neg_d;
    logic [OUT_W-1:0]   sinterm_q, sinterm_d, costerm_q, costerm_d;

    logic [PHASE_W-1:0] err_ext, inc, acc_next, ang_sum;
    logic [1:0]         q_sin, q_cos;
    logic [R_W-1:0]     r, a_sin, a_cos;
    logic [OUT_W-1:0]   sin_full, cos_full;

    assign err_ext  = PHASE_W'($signed(bus.error));
    assign inc      = fcw_q + (err_ext << ERR_SHIFT);
    assign acc_next = phase_acc_q + inc;
    assign ang_sum  = acc_next + bus.phase_offset;

    // Cosine is the sine lookup one quadrant ahead; odd quadrants read the table mirrored.
    assign q_sin    = ang_a_q[ANGLE_W-1 -: 2];
    assign q_cos    = q_sin + 2'd1;
    assign r        = ang_a_q[R_W-1:0];
    assign a_sin    = q_sin[0] ? ~r : r;
    assign a_cos    = q_cos[0] ? ~r : r;
    assign sin_full = {1'b0, sin_mag_q};
    assign cos_full = {1'b0, cos_mag_q};

    always_comb begin
        phase_acc_d = phase_acc_q;
        fcw_d       = fcw_q;
        ang_a_d     = ang_a_q;
        va_d        = 1'b0;
        vb_d        = 1'b0;
        out_valid_d = 1'b0;
        sin_mag_d   = sin_mag_q;
        cos_mag_d   = cos_mag_q;
        sin_neg_d   = sin_neg_q;
        cos_neg_d   = cos_neg_q;
        sinterm_d   = sinterm_q;
        costerm_d   = costerm_q;

        if (bus.fcw_load) fcw_d = bus.fcw_in;

        if (va_q) begin
            sin_mag_d = rom[a_sin];
            cos_mag_d = rom[a_cos];
            sin_neg_d = q_sin[1];
            cos_neg_d = q_cos[1];
        end

        if (bus.sync_clr) begin
            phase_acc_d = '0;
        end else begin
            va_d        = bus.in_valid;
            vb_d        = va_q;
            out_valid_d = vb_q;
            if (bus.in_valid) begin
                phase_acc_d = acc_next;
                ang_a_d     = ang_sum[PHASE_W-1 -: ANGLE_W];
            end
            if (vb_q) begin
                sinterm_d = sin_neg_q ? -sin_full : sin_full;
                costerm_d = cos_neg_q ? -cos_full : cos_full;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_acc_q <= '0;
            fcw_q       <= FCW_INIT;
            ang_a_q     <= '0;
            va_q        <= 1'b0;
            vb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sin_mag_q   <= '0;
            cos_mag_q   <= '0;
            sin_neg_q   <= 1'b0;
            cos_neg_q   <= 1'b0;
            sinterm_q   <= '0;
            costerm_q   <= '0;
        end else begin
            phase_acc_q <= phase_acc_d;
            fcw_q       <= fcw_d;
            ang_a_q     <= ang_a_d;
            va_q        <= va_d;
            vb_q        <= vb_d;
            out_valid_q <= out_valid_d;
            sin_mag_q   <= sin_mag_d;
            cos_mag_q   <= cos_mag_d;
            sin_neg_q   <= sin_neg_d;
            cos_neg_q   <= cos_neg_d;
            sinterm_q   <= sinterm_d;
            costerm_q   <= costerm_d;
        end
    end

    assign bus.phase_out = phase_acc_q;
    assign bus.sinterm   = sinterm_q;
    assign bus.costerm   = costerm_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_nco_quadlut.sv
// Bench for nco_quadlut: reference phase model plus a sin/cos scoreboard built from $sin.
module tb_nco_quadlut;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int          due;
        logic [15:0] s;
        logic [15:0] c;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nco_quadlut_if bus ();
    nco_quadlut dut (.clk(clk), .reset(reset), .bus(bus));

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] m_phase = '0;
    logic [31:0] m_fcw = '0;
    logic [15:0] last_s = '0;
    logic [15:0] last_c = '0;
    sb_t         sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Signed sine for 10-bit angle a, amplitude 32767, sampled at the bin centre.
    function automatic logic [15:0] exp_val(input int a);
        real v, mag;
        int  m;
        v   = $sin(2.0 * PI * (real'(a) + 0.5) / 1024.0);
        mag = (v < 0.0) ? -v : v;
        m   = $rtoi(mag * 32767.0 + 0.5);
        return (v < 0.0) ? 16'(-m) : 16'(m);
    endfunction

    // Drive one cycle; update the model and push the expected result; return at the next negedge.
    task automatic apply(input bit v, input logic [31:0] e, input bit fl, input logic [31:0] fi,
                         input logic [31:0] off, input bit clr);
        logic [31:0] sum;
        int          ang;
        sb_t         it;
        bus.in_valid = v; bus.error = e; bus.fcw_load = fl;
        bus.fcw_in = fi; bus.phase_offset = off; bus.sync_clr = clr;
        if (clr) begin
            m_phase = '0;
            sb.delete();
        end else if (v) begin
            m_phase = m_phase + m_fcw + (e << 3);
            sum     = m_phase + off;
            ang     = int'(sum[31:22]);
            it.due  = cyc + 3;
            it.s    = exp_val(ang);
            it.c    = exp_val((ang + 256) % 1024);
            sb.push_back(it);
        end
        if (fl) m_fcw = fi;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.error = '0; bus.fcw_load = 1'b0;
        bus.fcw_in = '0; bus.phase_offset = '0; bus.sync_clr = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL reset_phase: got %h want 0", bus.phase_out); end
        total++; if (bus.sinterm !== 16'h0) begin bad++; $display("FAIL reset_sin: got %h want 0", bus.sinterm); end
        total++; if (bus.costerm !== 16'h0) begin bad++; $display("FAIL reset_cos: got %h want 0", bus.costerm); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        sb_t it;
        bit  exp_ov;
        apply(0, 0, 1, 32'h0100_0000, 0, 0);
        for (int k = 1; k <= 263; k++) begin
            if (k <= 260) apply(1, 0, 0, 0, 0, 0);
            else apply(0, 0, 0, 0, 0, 0);
            if (k == 3) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.sinterm !== exp_val(4) || bus.costerm !== exp_val(260)) begin
                    bad++;
                    $display("FAIL first_out: got v=%b %h/%h want v=1 %h/%h", bus.out_valid, bus.sinterm, bus.costerm, exp_val(4), exp_val(260));
                end
            end
            total++;
            if (bus.phase_out !== m_phase) begin bad++; $display("FAIL basic_phase k=%0d: got %h want %h", k, bus.phase_out, m_phase); end
            exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
            total++;
            if (bus.out_valid !== exp_ov) begin bad++; $display("FAIL basic_valid k=%0d: got %b want %b", k, bus.out_valid, exp_ov); end
            if (exp_ov) begin
                it = sb.pop_front();
                total++;
                if (bus.sinterm !== it.s || bus.costerm !== it.c) begin
                    bad++; $display("FAIL basic_sincos k=%0d: got %h/%h want %h/%h", k, bus.sinterm, bus.costerm, it.s, it.c);
                end
            end
        end
    endtask

    task automatic test_error();
        apply(0, 0, 1, 32'h0, 0, 1);
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL err_clr: got %h want 0", bus.phase_out); end
        apply(1, 32'h1, 0, 0, 0, 0);
        total++; if (bus.phase_out !== 32'h8) begin bad++; $display("FAIL err_plus: got %h want 00000008", bus.phase_out); end
        apply(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL err_minus1: got %h want 00000000", bus.phase_out); end
        apply(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        total++; if (bus.phase_out !== 32'hFFFF_FFF8) begin bad++; $display("FAIL err_wrap: got %h want fffffff8", bus.phase_out); end
    endtask

    task automatic test_quadrant();
        int  idx_list[7] = '{0, 255, 256, 511, 512, 768, 1023};
        sb_t it;
        bit  exp_ov;
        apply(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            if (i < 7) apply(1, 0, 0, 0, 32'(idx_list[i]) << 22, 0);
            else apply(0, 0, 0, 0, 0, 0);
            total++;
            if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL quad_phase i=%0d: got %h want 0", i, bus.phase_out); end
            exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
            total++;
            if (bus.out_valid !== exp_ov) begin bad++; $display("FAIL quad_valid i=%0d: got %b want %b", i, bus.out_valid, exp_ov); end
            if (exp_ov) begin
                it = sb.pop_front();
                total++;
                if (bus.sinterm !== it.s || bus.costerm !== it.c) begin
                    bad++; $display("FAIL quad_sincos i=%0d: got %h/%h want %h/%h", i, bus.sinterm, bus.costerm, it.s, it.c);
                end
            end
        end
    endtask

    task automatic test_fcw_collision();
        logic [31:0] base;
        apply(0, 0, 1, 32'h10, 0, 0);
        base = m_phase;
        total++; if (bus.phase_out !== base) begin bad++; $display("FAIL fcw_idle: got %h want %h", bus.phase_out, base); end
        apply(1, 0, 1, 32'h20, 0, 0);
        total++; if (bus.phase_out !== base + 32'h10) begin bad++; $display("FAIL fcw_old: got %h want %h", bus.phase_out, base + 32'h10); end
        apply(1, 0, 0, 0, 0, 0);
        total++; if (bus.phase_out !== base + 32'h30) begin bad++; $display("FAIL fcw_new: got %h want %h", bus.phase_out, base + 32'h30); end
    endtask

    task automatic test_sync_clr();
        sb_t it;
        bit  exp_ov;
        for (int i = 0; i < 19; i++) begin
            if (i == 0) apply(0, 0, 1, 32'h0100_0000, 0, 0);
            else if (i == 7) apply(1, 0, 0, 0, 0, 1);
            else if (i < 16) apply(1, 0, 0, 0, 0, 0);
            else apply(0, 0, 0, 0, 0, 0);
            total++;
            if (bus.phase_out !== m_phase) begin bad++; $display("FAIL clr_phase i=%0d: got %h want %h", i, bus.phase_out, m_phase); end
            exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
            total++;
            if (bus.out_valid !== exp_ov) begin bad++; $display("FAIL clr_valid i=%0d: got %b want %b", i, bus.out_valid, exp_ov); end
            if (i >= 7 && i <= 9) begin
                total++;
                if (bus.out_valid !== 1'b0 || bus.sinterm !== last_s || bus.costerm !== last_c) begin
                    bad++; $display("FAIL clr_hold i=%0d: got v=%b %h/%h want v=0 %h/%h", i, bus.out_valid, bus.sinterm, bus.costerm, last_s, last_c);
                end
            end
            if (exp_ov) begin
                it = sb.pop_front();
                total++;
                if (bus.sinterm !== it.s || bus.costerm !== it.c) begin
                    bad++; $display("FAIL clr_sincos i=%0d: got %h/%h want %h/%h", i, bus.sinterm, bus.costerm, it.s, it.c);
                end
                last_s = it.s;
                last_c = it.c;
            end
        end
    endtask

    task automatic test_async_reset();
        sb.delete();
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 0, 0, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", bus.out_valid); end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL areset_phase: got %h want 0", bus.phase_out); end
        total++; if (bus.sinterm !== 16'h0) begin bad++; $display("FAIL areset_sin: got %h want 0", bus.sinterm); end
        total++; if (bus.costerm !== 16'h0) begin bad++; $display("FAIL areset_cos: got %h want 0", bus.costerm); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
        @(negedge clk);
        reset = 1'b1;
        m_phase = '0; m_fcw = '0; sb.delete();
        apply(1, 0, 0, 0, 0, 0);
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL areset_fcw: got %h want 0", bus.phase_out); end
        apply(1, 32'h1, 0, 0, 0, 0);
        total++; if (bus.phase_out !== 32'h8) begin bad++; $display("FAIL areset_resume: got %h want 00000008", bus.phase_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_quadrant();
        test_fcw_collision();
        test_sync_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
